// File: rtl/twiddle_mul_pkg.sv
// -----------------------------------------------------------------------------
// twiddle_mul_pkg
// Shared constants, types and the twiddle ROM builder for the NTT twiddle
// multiplier.
//   N, R, Q, W, A : transform size, radix (lanes), modulus, coefficient
//                   width, address width
//   OMEGA         : primitive N-th root of unity mod Q
//   coeff_t       : one W-bit coefficient
//   lanes_t       : R coefficients, one per lane
//   address_t     : R twiddle exponents of A bits each
//   init_rom()    : builds the constant table omega^i mod Q, i = 0..N-1
// -----------------------------------------------------------------------------
package twiddle_mul_pkg;

    localparam int N = 256;
    localparam int R = 4;
    localparam int Q = 7681;
    localparam int W = 13;
    localparam int A = $clog2(N);

    // 62 is a primitive 512th root of unity mod 7681, so 62^2 has order 256
    // and OMEGA^128 = Q-1.
    localparam int OMEGA = 3844;

    // Barrett constants: the product is below 2^(2W), so k = 2W keeps the
    // quotient estimate within a small error of the true quotient.
    localparam int BARRETT_K = 2 * W;
    localparam int BARRETT_M = (1 << BARRETT_K) / Q;

    typedef logic [W-1:0]          coeff_t;
    typedef logic [R-1:0][W-1:0]   lanes_t;
    typedef logic [R-1:0][A-1:0]   address_t;
    typedef logic [N-1:0][W-1:0]   rom_t;

    function automatic rom_t init_rom();
        rom_t rom;
        int   acc;
        rom = '0;
        acc = 1;
        for (int i = 0; i < N; i++) begin
            rom[i] = coeff_t'(acc);
            acc    = (acc * OMEGA) % Q;
        end
        return rom;
    endfunction

endpackage

// File: rtl/mod_mul_barrett.sv
// -----------------------------------------------------------------------------
// mod_mul_barrett
// One lane of the twiddle multiplier: a W x W multiply into a 2W-bit product
// register, then a Barrett reduction into a fully reduced result register.
//   clk, rst_n : clock, asynchronous active-low reset
//   en_mul     : loads the product register (stage-2 valid)
//   en_red     : loads the result register (stage-3 valid)
//   a, b       : operands, any W-bit values
//   result     : (a * b) mod Q, in 0..Q-1
// -----------------------------------------------------------------------------
module mod_mul_barrett
    import twiddle_mul_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en_mul,
    input  logic   en_red,
    input  coeff_t a,
    input  coeff_t b,
    output coeff_t result
);

    localparam int PW = 2 * W;   // full product width
    localparam int MW = W + 1;   // Barrett multiplier width

    localparam logic [MW-1:0] M_C = MW'(BARRETT_M);

    logic [PW-1:0]    prod_reg;
    coeff_t           result_reg;
    logic [PW+MW-1:0] mq;
    logic [MW-1:0]    qhat;
    logic [PW:0]      r0;
    logic [PW:0]      r1;
    logic [PW:0]      r2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_reg <= '0;
        end else if (en_mul) begin
            prod_reg <= PW'(a) * PW'(b);
        end
    end

    // qhat never exceeds the true quotient, so r0 is non-negative and at
    // most a couple of Q above the residue; two trims finish the job.
    always_comb begin
        mq   = (PW+MW)'(prod_reg) * (PW+MW)'(M_C);
        qhat = MW'(mq >> BARRETT_K);
        r0   = (PW+1)'(prod_reg) - ((PW+1)'(qhat) * (PW+1)'(Q));
        r1   = (r0 >= (PW+1)'(Q)) ? r0 - (PW+1)'(Q) : r0;
        r2   = (r1 >= (PW+1)'(Q)) ? r1 - (PW+1)'(Q) : r1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_reg <= '0;
        end else if (en_red) begin
            result_reg <= coeff_t'(r2);
        end
    end

    assign result = result_reg;

endmodule

// File: rtl/twiddle_mul.sv
// -----------------------------------------------------------------------------
// twiddle_mul
// Multiplies each butterfly output lane by its twiddle factor omega^addr mod Q.
// Three register stages: ROM read + data capture, multiply, Barrett reduce.
// A new lane group is accepted every cycle; there is no backpressure.
//   clk, rst_n : clock, asynchronous active-low reset
//   en_in      : lane group valid
//   addr_in    : twiddle exponents, lanes 1..R-1 (lane 0 ignored)
//   data_in    : one coefficient per lane
//   valid_out  : data_out holds a result, 3 cycles after en_in was sampled
//   data_out   : lane-wise products, fully reduced; lane 0 = data_in mod Q
// -----------------------------------------------------------------------------
module twiddle_mul
    import twiddle_mul_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     en_in,
    input  address_t addr_in,
    input  lanes_t   data_in,
    output logic     valid_out,
    output lanes_t   data_out
);

    localparam rom_t TWIDDLE_ROM = init_rom();

    logic [2:0] valid_reg;
    lanes_t     tw_reg;
    lanes_t     data_reg;

    // Lane 0 always multiplies by 1, so its exponent is never looked at.
    logic unused_lane0_addr;
    assign unused_lane0_addr = ^addr_in[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= '0;
        end else begin
            valid_reg <= {valid_reg[1:0], en_in};
        end
    end

    // Stage 1: registered ROM read per lane plus the matching data word.
    // Exponents are A bits wide, so wrap-around upstream is naturally mod N.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tw_reg   <= '0;
            data_reg <= '0;
        end else if (en_in) begin
            data_reg  <= data_in;
            tw_reg[0] <= coeff_t'(1);
            for (int i = 1; i < R; i++) begin
                tw_reg[i] <= TWIDDLE_ROM[addr_in[i]];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < R; gi++) begin : g_lane
            mod_mul_barrett u_mul (
                .clk    (clk),
                .rst_n  (rst_n),
                .en_mul (valid_reg[0]),
                .en_red (valid_reg[1]),
                .a      (data_reg[gi]),
                .b      (tw_reg[gi]),
                .result (data_out[gi])
            );
        end
    endgenerate

    assign valid_out = valid_reg[2];

endmodule

// File: tb/tb_twiddle_mul.sv
// -----------------------------------------------------------------------------
// tb_twiddle_mul
// Scoreboard bench: each accepted lane group pushes its expected products and
// its drive cycle; the monitor pops and compares when the result is due.
// -----------------------------------------------------------------------------
module tb_twiddle_mul;
    import twiddle_mul_pkg::*;

    localparam int Q_TB     = 7681;
    localparam int OMEGA_TB = 3844;
    localparam int LAT      = 3;

    typedef struct {
        lanes_t data;
        int     cyc;
    } exp_t;

    logic     clk;
    logic     rst_n;
    logic     en_in;
    address_t addr_in;
    lanes_t   data_in;
    logic     valid_out;
    lanes_t   data_out;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_txn = 0;
    exp_t sb[$];

    twiddle_mul dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_in     (en_in),
        .addr_in   (addr_in),
        .data_in   (data_in),
        .valid_out (valid_out),
        .data_out  (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int tw_pow(input int e);
        int acc = 1;
        for (int k = 0; k < e; k++) acc = (acc * OMEGA_TB) % Q_TB;
        return acc;
    endfunction

    task automatic drive(input logic en, input address_t addr, input lanes_t data);
        exp_t e;
        @(posedge clk); #1;
        en_in   = en;
        addr_in = addr;
        data_in = data;
        if (en && rst_n) begin
            for (int i = 0; i < R; i++) begin
                int tw;
                tw = (i == 0) ? 1 : tw_pow(int'(addr[i]));
                e.data[i] = coeff_t'((int'(data[i]) * tw) % Q_TB);
            end
            e.cyc = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic set_rst(input logic v);
        @(posedge clk); #1;
        rst_n = v;
        en_in = 1'b0;
        if (!v) sb.delete();
    endtask

    function automatic lanes_t fill(input int v);
        lanes_t d;
        for (int i = 0; i < R; i++) d[i] = coeff_t'(v);
        return d;
    endfunction

    function automatic address_t afill(input int v);
        address_t a;
        for (int i = 0; i < R; i++) a[i] = A'(v);
        return a;
    endfunction

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            check_val("rst_valid_out", valid_out, 0);
            check_val("rst_data_out", data_out, 0);
        end else if (sb.size() > 0 && sb[0].cyc + LAT == cyc) begin
            exp_t e;
            e = sb.pop_front();
            check_val("valid_out_due", valid_out, 1);
            for (int i = 0; i < R; i++) begin
                check_val($sformatf("lane%0d", i), data_out[i], e.data[i]);
            end
            n_txn++;
            $display("txn %0d cyc %0d out %0d %0d %0d %0d", n_txn, cyc,
                     data_out[0], data_out[1], data_out[2], data_out[3]);
        end else if (valid_out) begin
            check_val("spurious_valid_out", valid_out, 0);
        end
    end

    initial begin
        address_t a;
        lanes_t   d;
        int       wait_cnt;

        rst_n   = 1'b0;
        en_in   = 1'b0;
        addr_in = '0;
        data_in = '0;

        // Reset held 3 cycles with en_in high: nothing may come out.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < R; i++) d[i] = coeff_t'($urandom_range(0, 8191));
            drive(1'b1, afill(7), d);
        end
        set_rst(1'b1);

        // Unit vector: lanes read ROM[5], ROM[17], ROM[200]; lane 0 stays 1.
        a    = '0;
        a[1] = A'(5);
        a[2] = A'(17);
        a[3] = A'(200);
        drive(1'b1, a, fill(1));

        // Negation and exact pass-through boundaries.
        drive(1'b1, afill(128), fill(2));
        drive(1'b1, afill(0), fill(Q_TB - 1));
        drive(1'b1, afill(0), fill(8191));
        drive(1'b1, afill(0), fill(Q_TB));
        drive(1'b1, afill(255), fill(8191));
        drive(1'b0, '0, '0);
        drive(1'b0, '0, '0);
        drive(1'b0, '0, '0);
        drive(1'b0, '0, '0);
        check_val("sb_empty_after_directed", sb.size(), 0);

        // Streaming: 64 back-to-back random groups, then a 2-cycle gap.
        for (int k = 0; k < 64; k++) begin
            for (int i = 0; i < R; i++) begin
                d[i] = coeff_t'($urandom_range(0, 8191));
                a[i] = A'($urandom_range(0, 255));
            end
            drive(1'b1, a, d);
        end
        drive(1'b0, '0, '0);
        drive(1'b0, '0, '0);
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < R; i++) begin
                d[i] = coeff_t'($urandom_range(0, 8191));
                a[i] = A'($urandom_range(0, 255));
            end
            drive(1'b1, a, d);
        end
        for (int k = 0; k < 5; k++) drive(1'b0, '0, '0);

        // Mid-stream reset: two accepted items are flushed.
        drive(1'b1, afill(3), fill(100));
        drive(1'b1, afill(9), fill(200));
        set_rst(1'b0);
        set_rst(1'b1);
        for (int k = 0; k < 6; k++) drive(1'b0, '0, '0);
        drive(1'b1, afill(64), fill(4321));
        drive(1'b0, '0, '0);

        wait_cnt = 0;
        while (sb.size() > 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        check_val("drain_timeout", sb.size(), 0);
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/twiddle_mul.md
TWIDDLE_MUL -- requirements
Module: twiddle_mul

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 en_in  input  1  lane-group valid; driven by one bit of the stage butterfly enable BF_en[k].
REQ-004 addr_in  input  address_t  R-1 twiddle exponents; lanes 1..R-1 come from controller twiddle0/twiddle1, lane 0 is unused.
REQ-005 data_in  input  R x W  butterfly outputs, one coefficient per lane.
REQ-006 valid_out  output  1  data_out holds a valid result.
REQ-007 data_out  output  R x W  lane-wise product data_in[i] * omega^addr_in[i] mod Q; lane 0 passes through reduced.

Function
REQ-008 Parameters SHALL be N=256, R=4, Q=7681, W=13, A=$clog2(N)=8, all taken from the shared package.
REQ-009 The twiddle ROM SHALL hold N entries, entry i = omega^i mod Q, where omega is a primitive N-th root of unity mod Q.
REQ-010 The pipeline SHALL have exactly 3 register stages: S1 ROM read plus data register, S2 W x W multiply (2W-bit product), S3 Barrett reduction.
REQ-011 Latency SHALL be 3 cycles: en_in high at edge t gives valid_out high after edge t+3, with the matching data.
REQ-012 valid SHALL propagate through a 3-bit shift register; no backpressure exists, and a new input is accepted every cycle.
REQ-013 Data registers SHALL load only when the matching stage valid bit is set; when valid is low they hold their value.
REQ-014 Addresses SHALL be taken modulo N, i.e. the low A bits; upstream wrap-around (index*counter overflow) is legal.
REQ-015 Address 0 SHALL read ROM value 1 and give an exact pass-through reduced mod Q.
REQ-016 Lane 0 SHALL multiply by the constant 1 through the same pipeline, so all lanes stay aligned.
REQ-017 The result SHALL be fully reduced (0..Q-1) for any W-bit input, including inputs >= Q; Barrett may apply at most two conditional subtractions of Q.
REQ-018 The product SHALL be computed at 2W bits with no truncation before reduction.
REQ-019 Back-to-back en_in pulses with different addresses SHALL produce independent, correctly ordered results with no bubbles.

Reset
REQ-020 While rst_n is low: valid pipeline = 0, valid_out = 0, all data registers = 0, data_out = 0.
REQ-021 Reset asserted mid-operation SHALL flush all in-flight items; none appear after deassertion.
REQ-022 The first en_in sampled after deassertion SHALL produce valid_out exactly 3 cycles later.

Structure
REQ-023 The shared package SHALL define N, R, Q, W, A, omega, the coeff_t (W-bit) and address_t (array of R lanes of A bits) typedefs, and the twiddle ROM init function.
REQ-024 One sub-module, mod_mul_barrett (one lane, 2 registered stages: multiply, then reduce), SHALL be instantiated R times.
REQ-025 The ROM SHALL be a registered read, inferable as block RAM, one read port per lane 1..R-1.

Verification
REQ-026 Reset check: rst_n low for 3 cycles with en_in=1 -> valid_out=0 and data_out=0 throughout, and for 3 cycles after release only the newly entered items emerge.
REQ-027 Unit vector: data_in all lanes = 1, addr lanes = {5,17,200} -> lanes 1..3 = ROM[5], ROM[17], ROM[200], lane 0 = 1, 3 cycles later.
REQ-028 Negation: data=2, addr=128 on all lanes -> 7679 (omega^128 = -1), and data=Q-1, addr=0 -> 7680.
REQ-029 Out-of-range input: data=8191, addr=0 -> 510; data=7681, addr=0 -> 0.
REQ-030 Streaming: en_in high 64 consecutive cycles with random data and addresses -> 64 consecutive valid_out cycles matching a golden model in order; an en_in gap gives the same gap on valid_out.
REQ-031 Mid-stream reset: assert rst_n for 1 cycle after 2 accepted items -> neither item appears and valid_out stays 0 until a new en_in arrives, then 3 cycles later.
